xadc_drp_sched: RTL

XADC_DRP_SCHED -- requirements
Module: xadc_drp_sched

---
 rtl/xadc_sched_pkg.sv | 32 +++
 rtl/xadc_rr_pick.sv | 40 ++++
 rtl/xadc_drp_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/xadc_sched_pkg.sv
// xadc_sched_pkg
// Shared definitions for the XADC DRP scan scheduler:
//   - FSM state encodings (IDLE / ISSUE / WAIT_RDY)
//   - DRP addresses of the four scanned auxiliary channels
//   - default DRP timeout and channel count
//   - ch_addr(): channel index -> DRP address
package xadc_sched_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RDY = 2'd2;

  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int NUM_CH_DEF      = 4;

  localparam logic [6:0] ADDR_CH0 = 7'h16;
  localparam logic [6:0] ADDR_CH1 = 7'h17;
  localparam logic [6:0] ADDR_CH2 = 7'h1E;
  localparam logic [6:0] ADDR_CH3 = 7'h1F;

  function automatic logic [6:0] ch_addr(input logic [1:0] ch);
    logic [6:0] addr;
    case (ch)
      2'd0:    addr = ADDR_CH0;
      2'd1:    addr = ADDR_CH1;
      2'd2:    addr = ADDR_CH2;
      default: addr = ADDR_CH3;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/xadc_rr_pick.sv
// xadc_rr_pick
// Combinational round-robin selector: returns the first enabled channel
// strictly after last_ch, wrapping 3 -> 0. last_ch itself is the lowest
// priority candidate, so a single-channel mask keeps re-selecting it.
// Ports:
//   mask    in  4  per-channel enable
//   last_ch in  2  most recently serviced channel
//   next_ch out 2  selected channel (meaningless when found is low)
//   found   out 1  at least one channel enabled
module xadc_rr_pick
  import xadc_sched_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] last_ch,
  output logic [1:0] next_ch,
  output logic       found
);

  logic [1:0] cand [4];
  logic [3:0] hit;

  // cand[k] is the channel k+1 positions after last_ch (mod 4)
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = last_ch + 2'(gi + 1);
      assign hit[gi]  = mask[cand[gi]];
    end
  endgenerate

  always_comb begin
    next_ch = cand[0];
    found   = |hit;
    // Scan from farthest to nearest so the nearest enabled candidate wins.
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) next_ch = cand[k];
    end
  end

endmodule

// File: rtl/xadc_drp_sched.sv
// xadc_drp_sched
// Scans up to four XADC auxiliary channels over the DRP. Each end-of-
// conversion pulse triggers one DRP read of the next enabled channel
// (round-robin); results are stored per channel and readable by the host.
// Ports:
//   CLK100MHZ     in   1  clock (rising edge)
//   reset         in   1  synchronous active-high reset
//   eoc_in        in   1  XADC end-of-conversion pulse
//   ch_mask       in   4  per-channel scan enable
//   daddr_out     out  7  DRP address
//   den_out       out  1  DRP enable (one-cycle pulse)
//   drdy_in       in   1  DRP data ready
//   do_in         in  16  DRP read data
//   rd_sel        in   2  host channel select
//   rd_data       out 16  stored result of rd_sel (registered)
//   rd_valid      out  1  rd_sel holds a result (registered)
//   sample_strobe out  1  one-cycle pulse on each store
//   sample_ch     out  2  channel stored, valid with sample_strobe
//   timeout_err   out  1  sticky DRP timeout flag
// Build option: define XADC_SCHED_AVG_EN to store the average of every
// four samples per channel instead of each raw sample.
module xadc_drp_sched
  import xadc_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int NUM_CH      = NUM_CH_DEF
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        eoc_in,
  input  logic [3:0]  ch_mask,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  input  logic [1:0]  rd_sel,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        sample_strobe,
  output logic [1:0]  sample_ch,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       state_reg;
  logic [1:0]       sel_ch_reg;
  logic [1:0]       last_ch_reg;
  logic             pending_reg;
  logic [6:0]       daddr_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;
  logic             timeout_err_reg;
  logic             strobe_reg;
  logic [1:0]       sample_ch_reg;
  logic [15:0]      rd_data_reg;
  logic             rd_valid_reg;

  logic [1:0]  pick_ch;
  logic        pick_found;
  logic        capture;
  logic        store_now;

  logic [15:0]       result_vec [NUM_CH];
  logic [NUM_CH-1:0] valid_vec;
  logic [NUM_CH-1:0] store_ready;

  xadc_rr_pick u_pick (
    .mask    (ch_mask),
    .last_ch (last_ch_reg),
    .next_ch (pick_ch),
    .found   (pick_found)
  );

  // drdy_in only counts while a read is outstanding.
  assign capture   = (state_reg == ST_WAIT_RDY) && drdy_in;
  // In averaging builds only the 4th sample of a channel produces a store.
  assign store_now = capture && store_ready[sel_ch_reg];

  // ---------------- per-channel result storage ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic        hit;
      logic [15:0] result_reg;
      logic        valid_reg;

      assign hit = capture && (sel_ch_reg == 2'(gi));

`ifdef XADC_SCHED_AVG_EN
      logic [17:0] acc_reg;
      logic [1:0]  cnt_reg;
      logic [17:0] acc_next;

      assign acc_next        = acc_reg + 18'(do_in);
      assign store_ready[gi] = (cnt_reg == 2'd3);

      always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
          result_reg <= '0;
          valid_reg  <= 1'b0;
          acc_reg    <= '0;
          cnt_reg    <= '0;
        end else if (hit) begin
          if (cnt_reg == 2'd3) begin
            result_reg <= acc_next[17:2];
            valid_reg  <= 1'b1;
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + 2'd1;
          end
        end
      end
`else
      assign store_ready[gi] = 1'b1;

      always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
          result_reg <= '0;
          valid_reg  <= 1'b0;
        end else if (hit) begin
          result_reg <= do_in;
          valid_reg  <= 1'b1;
        end
      end
`endif

      assign result_vec[gi] = result_reg;
      assign valid_vec[gi]  = valid_reg;
    end
  endgenerate

  // ---------------- scheduler FSM ----------------
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      sel_ch_reg      <= 2'd0;
      last_ch_reg     <= 2'd3;
      pending_reg     <= 1'b0;
      daddr_reg       <= ADDR_CH0;
      tmo_cnt_reg     <= '0;
      timeout_err_reg <= 1'b0;
      strobe_reg      <= 1'b0;
      sample_ch_reg   <= 2'd0;
    end else begin
      strobe_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!pick_found) begin
            // Nothing to scan: drop any remembered request.
            pending_reg <= 1'b0;
          end else if (eoc_in || pending_reg) begin
            sel_ch_reg  <= pick_ch;
            daddr_reg   <= ch_addr(pick_ch);
            pending_reg <= 1'b0;
            state_reg   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (eoc_in) pending_reg <= 1'b1;
          tmo_cnt_reg <= '0;
          state_reg   <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (eoc_in) pending_reg <= 1'b1;
          if (drdy_in) begin
            last_ch_reg <= sel_ch_reg;
            state_reg   <= ST_IDLE;
            if (store_now) begin
              strobe_reg    <= 1'b1;
              sample_ch_reg <= sel_ch_reg;
            end
          end else if (tmo_cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Give up on this channel; the next pick moves past it.
            timeout_err_reg <= 1'b1;
            last_ch_reg     <= sel_ch_reg;
            state_reg       <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // ---------------- host read port ----------------
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_data_reg  <= result_vec[rd_sel];
      rd_valid_reg <= valid_vec[rd_sel];
    end
  end

  assign den_out       = (state_reg == ST_ISSUE);
  assign daddr_out     = daddr_reg;
  assign sample_strobe = strobe_reg;
  assign sample_ch     = sample_ch_reg;
  assign timeout_err   = timeout_err_reg;
  assign rd_data       = rd_data_reg;
  assign rd_valid      = rd_valid_reg;

endmodule
